// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO, any depth >= 2, with count, almost flags and sticky errors.
// Define SYNC_FIFO_FLAGS_OUTREG_EN for a registered read port (default: show-ahead).
module sync_fifo_flags #(
  parameter int DataWidth         = 32,
  parameter int Depth             = 8,
  parameter int AlmostFullThresh  = Depth - 2,
  parameter int AlmostEmptyThresh = 2,
  localparam int CountWidth       = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEn,
  input  logic [DataWidth-1:0]  writeData,
  input  logic                  readEn,
  output logic [DataWidth-1:0]  readData,
  output logic                  readValid,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [CountWidth-1:0] count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clearErr
);

  localparam int PtrWidth = $clog2(Depth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [DataWidth-1:0]  mem [Depth];
  logic [PtrWidth-1:0]   wrPtr;
  logic [PtrWidth-1:0]   rdPtr;
  logic                  readAcc;
  logic                  writeAcc;
  logic [CountWidth-1:0] countNext;

  // A full FIFO can still take a write when a read frees a slot this cycle.
  assign readAcc  = readEn && !empty;
  assign writeAcc = writeEn && (!full || readAcc);

  // Flags come straight off the count register.
  assign full        = (count == CountWidth'(Depth));
  assign empty       = (count == '0);
  assign almostFull  = (count >= CountWidth'(AlmostFullThresh));
  assign almostEmpty = (count <= CountWidth'(AlmostEmptyThresh));

  // Occupancy after this cycle's accepted requests.
  always_comb begin
    countNext = count;
    unique case ({writeAcc, readAcc})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Pointers, count and sticky error flags; a new error beats clearErr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (writeAcc) begin
        wrPtr <= (wrPtr == LastPtr) ? '0 : wrPtr + 1'b1;
      end
      if (readAcc) begin
        rdPtr <= (rdPtr == LastPtr) ? '0 : rdPtr + 1'b1;
      end
      count <= countNext;
      if (writeEn && !writeAcc) begin
        overflow <= 1'b1;
      end else if (clearErr) begin
        overflow <= 1'b0;
      end
      if (readEn && !readAcc) begin
        underflow <= 1'b1;
      end else if (clearErr) begin
        underflow <= 1'b0;
      end
    end
  end

  // Storage is never reset; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst && writeAcc) begin
      mem[wrPtr] <= writeData;
    end
  end

`ifdef SYNC_FIFO_FLAGS_OUTREG_EN
  // Registered read port: word and one-cycle valid pulse after each read.
  always_ff @(posedge clk) begin
    if (rst) begin
      readData  <= '0;
      readValid <= 1'b0;
    end else begin
      readValid <= readAcc;
      if (readAcc) begin
        readData <= mem[rdPtr];
      end
    end
  end
`else
  assign readData  = mem[rdPtr];
  assign readValid = !empty;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized scoreboard bench for sync_fifo_flags.
// Reference is a plain queue; read words are checked by a separate monitor.
module tb_sync_fifo_flags;

  localparam int DW    = 16;
  localparam int DEPTH = 5;
  localparam int AFT   = 4;
  localparam int AET   = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          writeEn = 1'b0;
  logic [DW-1:0] writeData = '0;
  logic          readEn = 1'b0;
  logic [DW-1:0] readData;
  logic          readValid;
  logic          full;
  logic          empty;
  logic          almostFull;
  logic          almostEmpty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
  logic          clearErr = 1'b0;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] expQ[$];
  bit            mOv = 0;
  bit            mUf = 0;
  bit            pulseNext = 0;

  sync_fifo_flags #(
    .DataWidth(DW),
    .Depth(DEPTH),
    .AlmostFullThresh(AFT),
    .AlmostEmptyThresh(AET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .writeEn(writeEn),
    .writeData(writeData),
    .readEn(readEn),
    .readData(readData),
    .readValid(readValid),
    .full(full),
    .empty(empty),
    .almostFull(almostFull),
    .almostEmpty(almostEmpty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .clearErr(clearErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp();
    if (expQ.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_read: got 0x%0h expected no word at %0t",
               readData, $time);
    end else begin
      chk("readData", {16'h0, readData}, {16'h0, expQ.pop_front()});
    end
  endtask

`ifdef SYNC_FIFO_FLAGS_OUTREG_EN
  // Registered port: a pulse must follow exactly the accepted reads.
  always @(posedge clk) begin
    bit pv;
    pv = pulseNext;
    #1;
    chk("readValid_pulse", {31'h0, readValid}, {31'h0, pv});
    if (readValid) pop_cmp();
  end
`else
  // Show-ahead: the head word is consumed when a read meets valid data.
  always @(negedge clk) begin
    #2;
    if (!rst && readEn && readValid) pop_cmp();
  end
`endif

  task automatic step(input bit r, input bit we, input bit re,
                      input bit ce, input logic [DW-1:0] d);
    bit rAcc;
    bit wAcc;
    int n;
    @(negedge clk);
    rst       = r;
    writeEn   = we;
    readEn    = re;
    clearErr  = ce;
    writeData = d;
    rAcc = !r && re && (mq.size() > 0);
    wAcc = !r && we && ((mq.size() < DEPTH) || rAcc);
    if (rAcc) expQ.push_back(mq[0]);
    pulseNext = rAcc;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mOv = 0;
      mUf = 0;
    end else begin
      if (rAcc) void'(mq.pop_front());
      if (wAcc) mq.push_back(d);
      if (we && !wAcc) mOv = 1;
      else if (ce) mOv = 0;
      if (re && !rAcc) mUf = 1;
      else if (ce) mUf = 0;
    end
    #1;
    n = mq.size();
    chk("count", {{(32-CW){1'b0}}, count}, n);
    chk("full", {31'h0, full}, {31'h0, n == DEPTH});
    chk("empty", {31'h0, empty}, {31'h0, n == 0});
    chk("almostFull", {31'h0, almostFull}, {31'h0, n >= AFT});
    chk("almostEmpty", {31'h0, almostEmpty}, {31'h0, n <= AET});
    chk("overflow", {31'h0, overflow}, {31'h0, mOv});
    chk("underflow", {31'h0, underflow}, {31'h0, mUf});
`ifdef SYNC_FIFO_FLAGS_OUTREG_EN
    if (r) chk("readData_reset", {16'h0, readData}, 32'h0);
`else
    chk("readValid", {31'h0, readValid}, {31'h0, n > 0});
`endif
  endtask

  initial begin
    int p;
    // Reset with junk requests present: they must be ignored.
    step(1, 1, 1, 0, 16'hdead);
    step(1, 0, 0, 0, 16'h0);
    // Fill 0x11..0x55, then drain in order.
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, DW'(i * 'h11));
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 16'h0);
    // Wrap-around with interleaved traffic.
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, DW'(16'h100 + i));
      if (i % 3 == 2) step(0, 1, 1, 0, DW'(16'h200 + i));
      step(0, 0, 1, 0, 16'h0);
    end
    while (mq.size() > 0) step(0, 0, 1, 0, 16'h0);
    // Overflow at full, clear, then write+clear keeps it set.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, DW'(16'h300 + i));
    step(0, 1, 0, 0, 16'hbad0);
    step(0, 0, 0, 1, 16'h0);
    step(0, 1, 0, 1, 16'hbad1);
    // Simultaneous read+write at full replaces the oldest in order.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, DW'(16'h400 + i));
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    // Underflow on empty, then read+write on empty.
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    step(0, 1, 1, 0, 16'h0500);
    step(0, 0, 1, 0, 16'h0);
    // Reset mid-traffic with count 3.
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, DW'(16'h600 + i));
    step(1, 1, 1, 0, 16'h0bad);
    step(0, 0, 0, 0, 16'h0);
    // Random traffic with a drifting write/read balance.
    for (int i = 0; i < 600; i++) begin
      p = (i / 50) % 3;
      step(($urandom_range(199) == 0),
           ($urandom_range(9) < (p == 0 ? 8 : p == 1 ? 2 : 5)),
           ($urandom_range(9) < (p == 0 ? 2 : p == 1 ? 8 : 5)),
           ($urandom_range(15) == 0),
           DW'($urandom));
    end
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL pending_reads: got %0d words unread expected 0",
               expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
